// File: rtl/phase_seq_responder.sv
// phase_seq_responder: responder end of the a->b->c->d phase handshake.
// Ports:
//   clk     - clock, all sampling on posedge
//   rst     - asynchronous active-high reset
//   a       - initiator request strobe, rising edge starts a sequence
//   b, c, d - back-to-back response phases (B_LEN, C_LEN, D_LEN cycles)
//   busy    - high while a sequence is in progress
//   done    - one-cycle pulse in the cycle d falls
//   overrun - one-cycle pulse when a rises while busy (rise is dropped)
module phase_seq_responder #(
    parameter int DELAY = 3,
    parameter int B_LEN = 4,
    parameter int C_LEN = 4,
    parameter int D_LEN = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic busy,
    output logic done,
    output logic overrun
);
    typedef enum logic [2:0] {IDLE, WAIT, PH_B, PH_C, PH_D} state_t;
    // Reload values; WAIT_LD is unused when DELAY==1 (entry goes straight to PH_B).
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(DELAY - 2);
    localparam logic [CNT_W-1:0] B_LD = CNT_W'(B_LEN - 1);
    localparam logic [CNT_W-1:0] C_LD = CNT_W'(C_LEN - 1);
    localparam logic [CNT_W-1:0] D_LD = CNT_W'(D_LEN - 1);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic a_q;
    logic rise;
    assign rise = a & ~a_q;
    assign b = state == PH_B;
    assign c = state == PH_C;
    assign d = state == PH_D;
    assign busy = state != IDLE;
    // a_q resets high so a strobe already high at reset release is not a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            a_q <= 1'b1;
            done <= 1'b0;
            overrun <= 1'b0;
        end else begin
            a_q <= a;
            done <= 1'b0;
            overrun <= rise && state != IDLE;
            case (state)
                IDLE: if (rise) begin
                    state <= DELAY == 1 ? PH_B : WAIT;
                    cnt <= DELAY == 1 ? B_LD : WAIT_LD;
                end
                WAIT: if (cnt == '0) begin
                    state <= PH_B;
                    cnt <= B_LD;
                end else cnt <= cnt - 1'b1;
                PH_B: if (cnt == '0) begin
                    state <= PH_C;
                    cnt <= C_LD;
                end else cnt <= cnt - 1'b1;
                PH_C: if (cnt == '0) begin
                    state <= PH_D;
                    cnt <= D_LD;
                end else cnt <= cnt - 1'b1;
                PH_D: if (cnt == '0) begin
                    state <= IDLE;
                    done <= 1'b1;
                end else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_seq_responder.sv
// tb_phase_seq_responder: directed table-driven bench for phase_seq_responder.
module tb_phase_seq_responder;
    typedef struct {
        logic a;
        logic [5:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0;
    logic a_min = 1'b0;
    logic b, c, d, busy, done, overrun;
    logic b_m, c_m, d_m, busy_m, done_m, overrun_m;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t tv[$];
    phase_seq_responder dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .busy(busy), .done(done), .overrun(overrun)
    );
    phase_seq_responder #(.DELAY(1), .B_LEN(1), .C_LEN(1), .D_LEN(1)) dut_min (
        .clk(clk), .rst(rst), .a(a_min), .b(b_m), .c(c_m), .d(d_m),
        .busy(busy_m), .done(done_m), .overrun(overrun_m)
    );
    always #5 clk = ~clk;
    // Expected {b,c,d,busy,done,overrun} after edge n for a rise accepted at edge k
    // with default parameters (DELAY=3, B/C/D_LEN=4).
    function automatic logic [5:0] seq(input int n, input int k);
        int r;
        r = n - k;
        return {r >= 2 && r <= 5, r >= 6 && r <= 9, r >= 10 && r <= 13, r >= 0 && r <= 13, r == 14, 1'b0};
    endfunction
    task automatic chk(input string name, input int n, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got bcd/busy/done/ovr=%b want %b", name, n, got, exp);
        end
    endtask
    task automatic step(input logic av, input logic am);
        @(negedge clk);
        a = av;
        a_min = am;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset(input logic av);
        @(negedge clk);
        rst = 1'b1;
        a = av;
        a_min = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic run_table(input string name, input logic on_min);
        for (int i = 0; i < tv.size(); i++) begin
            step(on_min ? 1'b0 : tv[i].a, on_min ? tv[i].a : 1'b0);
            chk(name, i + 1, on_min ? {b_m, c_m, d_m, busy_m, done_m, overrun_m}
                                    : {b, c, d, busy, done, overrun}, tv[i].exp);
        end
    endtask
    initial begin
        // reset state
        do_reset(1'b0);
        #1;
        chk("reset", 0, {b, c, d, busy, done, overrun}, 6'b0);
        chk("reset_min", 0, {b_m, c_m, d_m, busy_m, done_m, overrun_m}, 6'b0);
        // defaults: rise at edge 4 held high, drop at 19, back-to-back rise at 20
        tv.delete();
        for (int n = 1; n <= 26; n++)
            tv.push_back('{a: (n >= 4 && n != 19), exp: seq(n, 4) | seq(n, 20)});
        run_table("seq_b2b", 1'b0);
        // re-trigger mid-c (edge 12) and on the edge leaving PH_D (edge 18)
        for (int t = 0; t < 2; t++) begin
            int lo;
            lo = t == 0 ? 11 : 17;
            do_reset(1'b0);
            tv.delete();
            for (int n = 1; n <= 20; n++)
                tv.push_back('{a: (n >= 4 && n != lo), exp: seq(n, 4) | {5'b0, n == lo + 1}});
            run_table(t == 0 ? "retrig_c" : "retrig_d", 1'b0);
        end
        // reset mid-b with a held high
        do_reset(1'b0);
        for (int n = 1; n <= 9; n++) begin
            step(n >= 4, 1'b0);
            chk("pre_rst", n, {b, c, d, busy, done, overrun}, seq(n, 4));
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst", 9, {b, c, d, busy, done, overrun}, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step(1'b1, 1'b0);
            chk("post_rst", n, {b, c, d, busy, done, overrun}, 6'b0);
        end
        // a high through reset release, then a low pulse restarts
        do_reset(1'b1);
        for (int n = 1; n <= 5; n++) begin
            step(1'b1, 1'b0);
            chk("hold_high", n, {b, c, d, busy, done, overrun}, 6'b0);
        end
        step(1'b0, 1'b0);
        chk("hold_low", 6, {b, c, d, busy, done, overrun}, 6'b0);
        for (int i = 0; i <= 15; i++) begin
            step(1'b1, 1'b0);
            chk("restart", i + 7, {b, c, d, busy, done, overrun}, seq(i, 0));
        end
        // minimum parameters: rise at edge 2
        do_reset(1'b0);
        tv.delete();
        tv.push_back('{a: 1'b0, exp: 6'b000000});
        tv.push_back('{a: 1'b1, exp: 6'b100100});
        tv.push_back('{a: 1'b1, exp: 6'b010100});
        tv.push_back('{a: 1'b0, exp: 6'b001100});
        tv.push_back('{a: 1'b1, exp: 6'b000011});
        tv.push_back('{a: 1'b1, exp: 6'b000000});
        tv.push_back('{a: 1'b0, exp: 6'b000000});
        tv.push_back('{a: 1'b1, exp: 6'b100100});
        tv.push_back('{a: 1'b1, exp: 6'b010100});
        run_table("min", 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
